// File: rtl/lcd_responder.sv
// HD44780-style LCD bus responder: 2x16 DDRAM window, instruction decode,
// busy/clear sequencing, busy-flag and data readback, dropped-write reporting.
module lcd_responder #(
  parameter int unsigned BUSY_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       lcd_e,
  input  logic       lcd_rs,
  input  logic       lcd_rw,
  input  logic [7:0] lcd_db,
  output logic [7:0] lcd_q,
  output logic       busy,
  output logic [6:0] cur_addr,
  output logic       disp_on,
  output logic       cursor_on,
  output logic       blink_on,
  output logic       inc_mode,
  output logic       dropped,
  input  logic [4:0] view_idx,
  output logic [7:0] view_char
);

  localparam int unsigned DEPTH  = 32;
  localparam int unsigned IDX_W  = 5;
  localparam int unsigned ADDR_W = 7;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = (BUSY_CYCLES > 1) ? $clog2(BUSY_CYCLES) : 1;
  localparam logic [DATA_W-1:0] BLANK = 8'h20;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_CLEAR
  } state_t;

  state_t state, state_d;

  logic [CNT_W-1:0]  cnt, cnt_d;
  logic [IDX_W-1:0]  clr_idx, clr_d;
  logic              e_q;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              rise, fall;
  logic              wr_fall, accept, drop_c, rd_data_fall, is_clear;
  logic [ADDR_W-1:0] addr_d;
  logic              inc_d, disp_d, cursor_d, blink_d;
  logic              mem_we;
  logic [IDX_W-1:0]  mem_idx;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] rd_char;

  // Step the address counter; both display lines are 40 positions long and chain into each other.
  function automatic logic [ADDR_W-1:0] addr_step(input logic [ADDR_W-1:0] a, input logic up);
    logic [ADDR_W-1:0] r;
    if (up) begin
      if (a == 7'h27)      r = 7'h40;
      else if (a == 7'h67) r = 7'h00;
      else                 r = a + 7'd1;
    end else begin
      if (a == 7'h00)      r = 7'h67;
      else if (a == 7'h40) r = 7'h27;
      else                 r = a - 7'd1;
    end
    return r;
  endfunction

  function automatic logic is_mapped(input logic [ADDR_W-1:0] a);
    return (a[6:4] == 3'b000) || (a[6:4] == 3'b100);
  endfunction

  // 0x00-0x0F -> 0-15, 0x40-0x4F -> 16-31
  function automatic logic [IDX_W-1:0] map_idx(input logic [ADDR_W-1:0] a);
    return {a[6], a[3:0]};
  endfunction

  assign rise         = lcd_e & ~e_q;
  assign fall         = ~lcd_e & e_q;
  assign wr_fall      = fall & ~lcd_rw;
  assign accept       = wr_fall & (state == S_IDLE);
  assign drop_c       = wr_fall & (state != S_IDLE);
  assign rd_data_fall = fall & lcd_rw & lcd_rs;
  assign is_clear     = ~lcd_rs & (lcd_db == 8'h01);
  assign rd_char      = is_mapped(cur_addr) ? mem[map_idx(cur_addr)] : BLANK;
  assign view_char    = mem[view_idx];

  // Next-state logic for the busy/clear sequencer.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    clr_d   = clr_idx;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (is_clear) begin
            state_d = S_CLEAR;
            clr_d   = '0;
          end else begin
            state_d = S_BUSY;
            cnt_d   = CNT_W'(BUSY_CYCLES - 1);
          end
        end
      end
      S_BUSY: begin
        if (cnt == '0) state_d = S_IDLE;
        else           cnt_d   = cnt - CNT_W'(1);
      end
      S_CLEAR: begin
        clr_d = clr_idx + IDX_W'(1);
        if (clr_idx == IDX_W'(DEPTH - 1)) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Register updates from decoded writes, data reads and the clear sweep.
  always_comb begin
    addr_d    = cur_addr;
    inc_d     = inc_mode;
    disp_d    = disp_on;
    cursor_d  = cursor_on;
    blink_d   = blink_on;
    mem_we    = 1'b0;
    mem_idx   = '0;
    mem_wdata = BLANK;

    if (rd_data_fall) addr_d = addr_step(cur_addr, inc_mode);

    if (accept) begin
      if (lcd_rs) begin
        mem_we    = is_mapped(cur_addr);
        mem_idx   = map_idx(cur_addr);
        mem_wdata = lcd_db;
        addr_d    = addr_step(cur_addr, inc_mode);
      end else begin
        casez (lcd_db)
          8'b1???????: addr_d = lcd_db[6:0];
          8'b01??????,
          8'b001?????: ;
          8'b0001????: addr_d = addr_step(cur_addr, lcd_db[2]);
          8'b00001???: begin
            disp_d   = lcd_db[2];
            cursor_d = lcd_db[1];
            blink_d  = lcd_db[0];
          end
          8'b000001??: inc_d  = lcd_db[1];
          8'b0000001?: addr_d = '0;
          default: ;
        endcase
      end
    end

    // The final clear step owns the address counter and entry mode.
    if (state == S_CLEAR) begin
      mem_we    = 1'b1;
      mem_idx   = clr_idx;
      mem_wdata = BLANK;
      if (clr_idx == IDX_W'(DEPTH - 1)) begin
        addr_d = '0;
        inc_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      clr_idx <= '0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      clr_idx <= clr_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      e_q       <= 1'b0;
      busy      <= 1'b0;
      dropped   <= 1'b0;
      lcd_q     <= '0;
      cur_addr  <= '0;
      inc_mode  <= 1'b1;
      disp_on   <= 1'b0;
      cursor_on <= 1'b0;
      blink_on  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= BLANK;
    end else begin
      e_q       <= lcd_e;
      busy      <= (state_d != S_IDLE);
      dropped   <= drop_c;
      cur_addr  <= addr_d;
      inc_mode  <= inc_d;
      disp_on   <= disp_d;
      cursor_on <= cursor_d;
      blink_on  <= blink_d;
      if (rise && lcd_rw) lcd_q <= lcd_rs ? rd_char : {busy, cur_addr};
      if (mem_we) mem[mem_idx] <= mem_wdata;
    end
  end

endmodule

// File: tb/tb_lcd_responder.sv
// Testbench for lcd_responder: directed bus transactions against a position-based
// behavioural model, plus literal expectations for the key scenarios.
`timescale 1ns/1ps
module tb_lcd_responder;

  localparam int BC = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       lcd_e = 1'b0;
  logic       lcd_rs = 1'b0;
  logic       lcd_rw = 1'b0;
  logic [7:0] lcd_db = 8'h00;
  logic [4:0] view_idx = 5'd0;
  logic [7:0] lcd_q;
  logic       busy;
  logic [6:0] cur_addr;
  logic       disp_on, cursor_on, blink_on, inc_mode, dropped;
  logic [7:0] view_char;

  int n_checks = 0;
  int n_fail = 0;

  lcd_responder #(.BUSY_CYCLES(BC)) dut (
    .clk(clk), .rst(rst), .lcd_e(lcd_e), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
    .lcd_db(lcd_db), .lcd_q(lcd_q), .busy(busy), .cur_addr(cur_addr),
    .disp_on(disp_on), .cursor_on(cursor_on), .blink_on(blink_on),
    .inc_mode(inc_mode), .dropped(dropped), .view_idx(view_idx), .view_char(view_char)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: addresses as plain integers, DDRAM as an int array.
  int m_mem [32];
  int m_addr, m_q, m_busy_left;
  bit m_inc, m_disp, m_cur, m_blink, m_drop, m_clearing, m_eprev;

  function automatic int m_index(input int a);
    if (a < 16) return a;
    if (a >= 64 && a < 80) return a - 48;
    return -1;
  endfunction

  // Both lines form one 80-position ring: line 0 = 0..39, line 1 = 40..79.
  function automatic int m_move(input int a, input bit up);
    int p;
    if (a < 40) p = a;
    else if (a >= 64 && a < 104) p = a - 24;
    else return up ? (a + 1) % 128 : (a + 127) % 128;
    p = up ? (p + 1) % 80 : (p + 79) % 80;
    return (p < 40) ? p : p + 24;
  endfunction

  initial forever begin
    bit busy_now, rise, fall;
    int ix;
    @(posedge clk or negedge rst);
    if (!rst) begin
      for (int i = 0; i < 32; i++) m_mem[i] = 32;
      m_addr = 0; m_q = 0; m_busy_left = 0; m_inc = 1; m_disp = 0; m_cur = 0;
      m_blink = 0; m_drop = 0; m_clearing = 0; m_eprev = 0;
    end else begin
      busy_now = (m_busy_left > 0);
      rise = lcd_e && !m_eprev;
      fall = !lcd_e && m_eprev;
      m_eprev = lcd_e;
      m_drop = 0;
      if (rise && lcd_rw) begin
        if (lcd_rs) begin
          ix = m_index(m_addr);
          m_q = (ix < 0) ? 32 : m_mem[ix];
        end else begin
          m_q = (busy_now ? 128 : 0) + m_addr;
        end
      end
      if (fall && lcd_rw && lcd_rs) m_addr = m_move(m_addr, m_inc);
      if (m_busy_left > 0) begin
        m_busy_left--;
        if (m_clearing && m_busy_left == 0) begin
          m_clearing = 0; m_addr = 0; m_inc = 1;
          for (int i = 0; i < 32; i++) m_mem[i] = 32;
        end
      end
      if (fall && !lcd_rw) begin
        if (busy_now) m_drop = 1;
        else if (lcd_rs) begin
          ix = m_index(m_addr);
          if (ix >= 0) m_mem[ix] = int'(lcd_db);
          m_addr = m_move(m_addr, m_inc);
          m_busy_left = BC;
        end else if (lcd_db == 8'h01) begin
          m_busy_left = 32; m_clearing = 1;
        end else begin
          if (lcd_db >= 128) m_addr = int'(lcd_db) - 128;
          else if (lcd_db >= 32) begin end
          else if (lcd_db >= 16) m_addr = m_move(m_addr, lcd_db[2]);
          else if (lcd_db >= 8) begin
            m_disp = lcd_db[2]; m_cur = lcd_db[1]; m_blink = lcd_db[0];
          end
          else if (lcd_db >= 4) m_inc = lcd_db[1];
          else if (lcd_db >= 2) m_addr = 0;
          m_busy_left = BC;
        end
      end
    end
  end

  // Cycle-by-cycle comparison against the model.
  initial forever begin
    @(posedge clk);
    #2;
    check("busy", busy, m_busy_left > 0);
    check("cur_addr", cur_addr, m_addr);
    check("inc_mode", inc_mode, m_inc);
    check("disp_on", disp_on, m_disp);
    check("cursor_on", cursor_on, m_cur);
    check("blink_on", blink_on, m_blink);
    check("dropped", dropped, m_drop);
    check("lcd_q", lcd_q, m_q);
    if (!m_clearing) check("view_char", view_char, m_mem[view_idx]);
  end

  // All bus tasks start and end just after a falling clock edge.
  task automatic bus_write(input logic rs, input logic [7:0] d);
    lcd_rs = rs; lcd_rw = 1'b0; lcd_db = d; lcd_e = 1'b1;
    @(negedge clk); lcd_e = 1'b0;
    @(negedge clk);
  endtask

  task automatic bus_write_long(input logic rs, input logic [7:0] d, input int hold);
    lcd_rs = rs; lcd_rw = 1'b0; lcd_db = d; lcd_e = 1'b1;
    repeat (hold) @(negedge clk);
    lcd_e = 1'b0;
    @(negedge clk);
  endtask

  task automatic bus_read(input logic rs, output logic [7:0] q);
    lcd_rs = rs; lcd_rw = 1'b1; lcd_e = 1'b1;
    @(negedge clk); q = lcd_q; lcd_e = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100 && busy; i++) @(negedge clk);
    check("idle_timeout", busy, 1'b0);
  endtask

  task automatic wr(input logic rs, input logic [7:0] d);
    bus_write(rs, d);
    wait_idle();
  endtask

  task automatic count_busy(output int n);
    n = 0;
    for (int i = 0; i < 100 && busy; i++) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic check_char(input int idx, input int exp);
    view_idx = 5'(idx);
    #1;
    check($sformatf("char[%0d]", idx), view_char, exp);
    @(negedge clk);
  endtask

  initial begin
    int n;
    logic [7:0] q;

    repeat (3) @(negedge clk);
    check("rst_cur_addr", cur_addr, 7'h00);
    check("rst_inc_mode", inc_mode, 1'b1);
    check("rst_lcd_q", lcd_q, 8'h00);
    check("rst_busy", busy, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check_char(0, 8'h20);

    // Single data write and its busy window.
    bus_write(1'b1, 8'h41);
    count_busy(n);
    check("busy_len_data", n, BC);
    check("addr_after_A", cur_addr, 7'h01);
    check_char(0, 8'h41);

    // Second line addressing.
    wr(1'b0, 8'hC0); wr(1'b1, 8'h31); wr(1'b1, 8'h30);
    check_char(16, 8'h31);
    check_char(17, 8'h30);
    check("addr_line2", cur_addr, 7'h42);

    // Write inside the busy window is dropped.
    bus_write(1'b0, 8'h0E);
    bus_write(1'b0, 8'h0F);
    check("dropped_pulse", dropped, 1'b1);
    wait_idle();
    check("disp_on", disp_on, 1'b1);
    check("cursor_on", cursor_on, 1'b1);
    check("blink_off", blink_on, 1'b0);

    // Cursor shifts.
    wr(1'b0, 8'h14); check("shift_right", cur_addr, 7'h43);
    wr(1'b0, 8'h10); check("shift_left", cur_addr, 7'h42);

    // Decrement mode and line wraps.
    wr(1'b0, 8'h04); wr(1'b0, 8'h80); wr(1'b1, 8'h55);
    check_char(0, 8'h55);
    check("dec_wrap_0", cur_addr, 7'h67);
    wr(1'b0, 8'hA7); wr(1'b0, 8'h06); wr(1'b1, 8'h77);
    check("inc_wrap_27", cur_addr, 7'h40);
    check_char(16, 8'h31);
    wr(1'b0, 8'hE7); wr(1'b0, 8'h14); check("inc_wrap_67", cur_addr, 7'h00);
    wr(1'b0, 8'hC0); wr(1'b0, 8'h10); check("dec_wrap_40", cur_addr, 7'h27);

    // Data read with auto-advance, busy-flag reads.
    wr(1'b0, 8'hC0);
    bus_read(1'b1, q);
    check("read_char", q, 8'h31);
    check("read_advance", cur_addr, 7'h41);
    bus_write(1'b0, 8'h02);
    bus_read(1'b0, q);
    check("bf_during_busy", q, 8'h80);
    wait_idle();
    bus_read(1'b0, q);
    check("bf_idle", q, 8'h00);

    // Clear: 32 busy cycles, blank DDRAM, address and entry mode restored.
    wr(1'b0, 8'h04); wr(1'b0, 8'hC5);
    bus_write(1'b0, 8'h01);
    count_busy(n);
    check("busy_len_clear", n, 32);
    check("clear_addr", cur_addr, 7'h00);
    check("clear_inc", inc_mode, 1'b1);
    for (int i = 0; i < 32; i++) check_char(i, 8'h20);

    // Busy-flag read during clear.
    wr(1'b1, 8'h61); wr(1'b1, 8'h62);
    bus_write(1'b0, 8'h01);
    bus_read(1'b0, q);
    check("bf_in_clear", q[7], 1'b1);
    wait_idle();
    bus_read(1'b0, q);
    check("bf_after_clear", q, 8'h00);

    // Reset aborts a clear in progress.
    wr(1'b1, 8'h41);
    bus_write(1'b0, 8'h01);
    repeat (5) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_clear_busy", busy, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    wr(1'b1, 8'h42);
    check_char(0, 8'h42);
    check("post_rst_addr", cur_addr, 7'h01);

    // Reset aborts a busy window.
    bus_write(1'b1, 8'h43);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_busy", busy, 1'b0);
    check_char(1, 8'h20);
    wr(1'b0, 8'h0C);
    check("post_rst_decode", disp_on, 1'b1);

    // Long enable pulse produces exactly one transaction.
    bus_write_long(1'b1, 8'h61, 6);
    wait_idle();
    check("long_e_addr", cur_addr, 7'h01);
    check_char(0, 8'h61);
    check_char(1, 8'h20);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
